systolic_skew_feeder: RTL

- Front-end for systolic_array, parametrised in height, width and inner dimension K.
- Accepts one operand vector pair per step k: column k of A, one element per array row, and row k of B, one element per array column.
- Applies the diagonal skew the array needs (lane r delayed r cycles) and drives the array's per-lane row/col valid-ready ports.
- Asserts flush with each lane's final element, then reports completion. Replaces hand-sequenced bench stimulus and supports partial (masked) matrices.

---
 rtl/systolic_skew_feeder_if.sv | 42 ++++
 rtl/systolic_skew_feeder.sv | 139 +++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder_if.sv
// Bundle of the feeder's vector-input and systolic-array-side signals.
// The slave modport is the feeder; the master modport is whatever drives and consumes it.
interface systolic_skew_feeder_if #(
    parameter int unsigned width_p        = 32,
    parameter int unsigned array_width_p  = 2,
    parameter int unsigned array_height_p = 2,
    parameter int unsigned depth_p        = 16
) ();
    localparam int unsigned RowCntW = $clog2(array_height_p + 1);
    localparam int unsigned ColCntW = $clog2(array_width_p + 1);
    localparam int unsigned KCntW   = $clog2(depth_p + 1);

    logic                                vec_v_i;
    logic                                vec_ready_o;
    logic [width_p*array_height_p-1:0]   a_i;
    logic [width_p*array_width_p-1:0]    b_i;
    logic                                last_i;
    logic [RowCntW-1:0]                  active_rows_i;
    logic [ColCntW-1:0]                  active_cols_i;
    logic [width_p*array_height_p-1:0]   row_o;
    logic [array_height_p-1:0]           row_valid_o;
    logic [array_height_p-1:0]           row_ready_i;
    logic [width_p*array_width_p-1:0]    col_o;
    logic [array_width_p-1:0]            col_valid_o;
    logic [array_width_p-1:0]            col_ready_i;
    logic [array_height_p-1:0]           flush_o;
    logic [KCntW-1:0]                    k_count_o;
    logic                                done_o;
    logic                                overflow_o;

    modport slave (
        input  vec_v_i, a_i, b_i, last_i, active_rows_i, active_cols_i, row_ready_i, col_ready_i,
        output vec_ready_o, row_o, row_valid_o, col_o, col_valid_o, flush_o, k_count_o, done_o,
               overflow_o
    );

    modport master (
        output vec_v_i, a_i, b_i, last_i, active_rows_i, active_cols_i, row_ready_i, col_ready_i,
        input  vec_ready_o, row_o, row_valid_o, col_o, col_valid_o, flush_o, k_count_o, done_o,
               overflow_o
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Skewing front-end for a systolic array: lane r sees vector k r advances after lane 0,
// with per-lane valid/ready, flush on the final element and a done pulse per product.
module systolic_skew_feeder #(
    parameter int unsigned width_p        = 32,
    parameter int unsigned array_width_p  = 2,
    parameter int unsigned array_height_p = 2,
    parameter int unsigned depth_p        = 16
) (
    input logic                   clk_i,
    input logic                   reset_i,
    systolic_skew_feeder_if.slave bus
);
    localparam int unsigned H       = array_height_p;
    localparam int unsigned W       = array_width_p;
    localparam int unsigned D       = (H > W) ? H : W;
    localparam int unsigned RowCntW = $clog2(H + 1);
    localparam int unsigned ColCntW = $clog2(W + 1);
    localparam int unsigned KCntW   = $clog2(depth_p + 1);

    typedef enum logic [1:0] {StIdle, StFeed, StDrain, StDone} state_e;

    state_e state_q, state_d;

    logic [width_p*H-1:0] a_q [D];
    logic [width_p*W-1:0] b_q [D];
    logic [D-1:0]         last_q, valid_q;
    logic [RowCntW-1:0]   rows_q, rows_in;
    logic [ColCntW-1:0]   cols_q, cols_in;
    logic [KCntW-1:0]     k_count_q;
    logic                 overflow_q;
    logic [H-1:0]         row_valid;
    logic [W-1:0]         col_valid;
    logic                 advance, accept, drop, push, lower_empty, vec_ready, done;

    // Zero or out-of-range lane counts mean "use every lane".
    assign rows_in = (bus.active_rows_i == '0 || bus.active_rows_i > RowCntW'(H)) ?
                     RowCntW'(H) : bus.active_rows_i;
    assign cols_in = (bus.active_cols_i == '0 || bus.active_cols_i > ColCntW'(W)) ?
                     ColCntW'(W) : bus.active_cols_i;

    for (genvar r = 0; r < H; r++) begin : g_row
        assign row_valid[r] = valid_q[r] && (RowCntW'(r) < rows_q);
        assign bus.row_o[width_p*r +: width_p] = row_valid[r] ? a_q[r][width_p*r +: width_p] : '0;
        assign bus.flush_o[r] = row_valid[r] && last_q[r];
    end

    for (genvar c = 0; c < W; c++) begin : g_col
        assign col_valid[c] = valid_q[c] && (ColCntW'(c) < cols_q);
        assign bus.col_o[width_p*c +: width_p] = col_valid[c] ? b_q[c][width_p*c +: width_p] : '0;
    end

    // Only lanes currently presenting data can hold the pipeline.
    assign advance = (&(~row_valid | bus.row_ready_i)) && (&(~col_valid | bus.col_ready_i));
    assign accept  = bus.vec_v_i && vec_ready;
    assign drop    = !bus.last_i && (k_count_q == KCntW'(depth_p));
    assign push    = accept && !drop;

    always_comb begin
        lower_empty = 1'b1;
        for (int unsigned s = 0; s + 1 < D; s++) begin
            if (valid_q[s]) lower_empty = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= StIdle;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = bus.last_i ? StDrain : StFeed;
            StFeed:  if (accept && bus.last_i) state_d = StDrain;
            StDrain: if (advance && lower_empty) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        vec_ready = 1'b0;
        done      = 1'b0;
        case (state_q)
            StIdle, StFeed: vec_ready = advance && !overflow_q;
            StDone:         done      = 1'b1;
            default:        ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= '0;
            last_q  <= '0;
            for (int unsigned s = 0; s < D; s++) begin
                a_q[s] <= '0;
                b_q[s] <= '0;
            end
        end else if (advance) begin
            for (int unsigned s = 1; s < D; s++) begin
                a_q[s]     <= a_q[s-1];
                b_q[s]     <= b_q[s-1];
                last_q[s]  <= last_q[s-1];
                valid_q[s] <= valid_q[s-1];
            end
            a_q[0]     <= bus.a_i;
            b_q[0]     <= bus.b_i;
            last_q[0]  <= bus.last_i && push;
            valid_q[0] <= push;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            k_count_q  <= '0;
            overflow_q <= 1'b0;
            rows_q     <= RowCntW'(H);
            cols_q     <= ColCntW'(W);
        end else begin
            if (state_q == StDone) begin
                k_count_q <= '0;
            end else if (push && k_count_q != KCntW'(depth_p)) begin
                k_count_q <= k_count_q + KCntW'(1);
            end
            if (accept && drop) overflow_q <= 1'b1;
            if (state_q == StIdle && accept) begin
                rows_q <= rows_in;
                cols_q <= cols_in;
            end
        end
    end

    assign bus.vec_ready_o = vec_ready;
    assign bus.row_valid_o = row_valid;
    assign bus.col_valid_o = col_valid;
    assign bus.k_count_o   = k_count_q;
    assign bus.done_o      = done;
    assign bus.overflow_o  = overflow_q;
endmodule
